// File: rtl/cricket_ball_scorer.sv
// Turns each bat-button press into a ball outcome drawn from the LFSR value,
// and keeps the innings tally (runs, wickets, balls, overs) until the innings ends.
module cricket_ball_scorer #(
   parameter int unsigned MAX_OVERS   = 2,
   parameter int unsigned MAX_WICKETS = 10
) (
   input  logic       clk_fpga,
   input  logic       reset,
   input  logic       bat_btn,
   input  logic       new_innings,
   input  logic [3:0] rand_in,
   output logic [7:0] runs,
   output logic [3:0] wickets,
   output logic [2:0] balls,
   output logic [3:0] overs,
   output logic [2:0] last_runs,
   output logic       last_wicket,
   output logic       ball_valid,
   output logic       innings_over
);

   typedef enum logic {PLAY, DONE} state_t;

   state_t     state, state_d;
   logic       s1, s2, s3;
   logic       press_c;
   logic [2:0] credit_c;
   logic       wicket_c;
   logic [8:0] sum_c;
   logic [7:0] runs_d;
   logic [3:0] wickets_d;
   logic [2:0] balls_d;
   logic [3:0] overs_d;
   logic [2:0] last_runs_d;
   logic       last_wicket_d;
   logic       ball_valid_d;

   // Two-flop synchronizer plus history flop; s3 is never cleared by new_innings
   always_ff @(posedge clk_fpga or posedge reset) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= bat_btn;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign press_c = s2 & ~s3;

   // Outcome map from the random nibble
   always_comb begin
      credit_c = 3'd0;
      wicket_c = 1'b0;
      case (rand_in)
         4'd0, 4'd1, 4'd12:       credit_c = 3'd0;
         4'd2, 4'd3, 4'd4, 4'd13: credit_c = 3'd1;
         4'd5, 4'd6:              credit_c = 3'd2;
         4'd7:                    credit_c = 3'd3;
         4'd8, 4'd9:              credit_c = 3'd4;
         4'd10, 4'd11:            credit_c = 3'd6;
         default:                 wicket_c = 1'b1;
      endcase
   end

   // Next-state and tally update; new_innings overrides any press
   always_comb begin
      state_d       = state;
      runs_d        = runs;
      wickets_d     = wickets;
      balls_d       = balls;
      overs_d       = overs;
      last_runs_d   = last_runs;
      last_wicket_d = last_wicket;
      ball_valid_d  = 1'b0;
      sum_c         = 9'(runs) + 9'(credit_c);
      if (new_innings) begin
         state_d       = PLAY;
         runs_d        = 8'd0;
         wickets_d     = 4'd0;
         balls_d       = 3'd0;
         overs_d       = 4'd0;
         last_runs_d   = 3'd0;
         last_wicket_d = 1'b0;
      end else if (state == PLAY && press_c) begin
         runs_d = sum_c[8] ? 8'hFF : sum_c[7:0];
         if (wicket_c) begin
            wickets_d = wickets + 4'd1;
         end
         if (balls == 3'd5) begin
            balls_d = 3'd0;
            overs_d = overs + 4'd1;
         end else begin
            balls_d = balls + 3'd1;
         end
         last_runs_d   = credit_c;
         last_wicket_d = wicket_c;
         ball_valid_d  = 1'b1;
         if (wickets_d == 4'(MAX_WICKETS) || overs_d == 4'(MAX_OVERS)) begin
            state_d = DONE;
         end
      end
   end

   always_ff @(posedge clk_fpga or posedge reset) begin
      if (reset) begin
         state        <= PLAY;
         runs         <= 8'd0;
         wickets      <= 4'd0;
         balls        <= 3'd0;
         overs        <= 4'd0;
         last_runs    <= 3'd0;
         last_wicket  <= 1'b0;
         ball_valid   <= 1'b0;
         innings_over <= 1'b0;
      end else begin
         state        <= state_d;
         runs         <= runs_d;
         wickets      <= wickets_d;
         balls        <= balls_d;
         overs        <= overs_d;
         last_runs    <= last_runs_d;
         last_wicket  <= last_wicket_d;
         ball_valid   <= ball_valid_d;
         innings_over <= (state_d == DONE);
      end
   end

endmodule

// File: tb/tb_cricket_ball_scorer.sv
// Scoreboard bench: three scorer instances with different innings limits share stimulus;
// sel picks which one the monitor compares against the queued expected tallies.
module tb_cricket_ball_scorer;

   typedef struct packed {
      logic [7:0] runs;
      logic [3:0] wickets;
      logic [2:0] balls;
      logic [3:0] overs;
      logic [2:0] last_runs;
      logic       last_wicket;
      logic       innings_over;
   } tally_t;

   logic       clk_fpga = 1'b0;
   logic       reset;
   logic       bat_btn;
   logic       new_innings;
   logic [3:0] rand_in;

   logic [7:0] runs_o    [3];
   logic [3:0] wickets_o [3];
   logic [2:0] balls_o   [3];
   logic [3:0] overs_o   [3];
   logic [2:0] lruns_o   [3];
   logic       lwk_o     [3];
   logic       vld_o     [3];
   logic       done_o    [3];

   int     total = 0;
   int     bad   = 0;
   int     cyc   = 0;
   int     sel   = 0;
   tally_t exp_q [$];
   int     cyc_q [$];

   always #5 clk_fpga = ~clk_fpga;
   always @(posedge clk_fpga) cyc <= cyc + 1;

   cricket_ball_scorer #(.MAX_OVERS(2), .MAX_WICKETS(10)) dut_a (
      .clk_fpga(clk_fpga), .reset(reset), .bat_btn(bat_btn), .new_innings(new_innings),
      .rand_in(rand_in), .runs(runs_o[0]), .wickets(wickets_o[0]), .balls(balls_o[0]),
      .overs(overs_o[0]), .last_runs(lruns_o[0]), .last_wicket(lwk_o[0]),
      .ball_valid(vld_o[0]), .innings_over(done_o[0]));

   cricket_ball_scorer #(.MAX_OVERS(2), .MAX_WICKETS(3)) dut_b (
      .clk_fpga(clk_fpga), .reset(reset), .bat_btn(bat_btn), .new_innings(new_innings),
      .rand_in(rand_in), .runs(runs_o[1]), .wickets(wickets_o[1]), .balls(balls_o[1]),
      .overs(overs_o[1]), .last_runs(lruns_o[1]), .last_wicket(lwk_o[1]),
      .ball_valid(vld_o[1]), .innings_over(done_o[1]));

   cricket_ball_scorer #(.MAX_OVERS(15), .MAX_WICKETS(10)) dut_c (
      .clk_fpga(clk_fpga), .reset(reset), .bat_btn(bat_btn), .new_innings(new_innings),
      .rand_in(rand_in), .runs(runs_o[2]), .wickets(wickets_o[2]), .balls(balls_o[2]),
      .overs(overs_o[2]), .last_runs(lruns_o[2]), .last_wicket(lwk_o[2]),
      .ball_valid(vld_o[2]), .innings_over(done_o[2]));

   function automatic tally_t act(input int s);
      tally_t t;
      t.runs         = runs_o[s];
      t.wickets      = wickets_o[s];
      t.balls        = balls_o[s];
      t.overs        = overs_o[s];
      t.last_runs    = lruns_o[s];
      t.last_wicket  = lwk_o[s];
      t.innings_over = done_o[s];
      return t;
   endfunction

   function automatic tally_t mk(input int r, input int w, input int b, input int o,
                                 input int lr, input int lw, input int d);
      tally_t t;
      t.runs         = 8'(r);
      t.wickets      = 4'(w);
      t.balls        = 3'(b);
      t.overs        = 4'(o);
      t.last_runs    = 3'(lr);
      t.last_wicket  = 1'(lw);
      t.innings_over = 1'(d);
      return t;
   endfunction

   // Monitor: every ball_valid pulse must match the oldest queued expectation and its cycle
   always @(negedge clk_fpga) begin
      if (vld_o[sel] === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_ball_valid inst=%0d cyc=%0d got=1 want=0", sel, cyc);
         end else begin
            tally_t e;
            tally_t a;
            int     ec;
            e  = exp_q.pop_front();
            ec = cyc_q.pop_front();
            a  = act(sel);
            if (a !== e || cyc != ec) begin
               bad++;
               $display("FAIL ball_tally inst=%0d got=%h@cyc%0d want=%h@cyc%0d", sel, a, cyc, e, ec);
            end
         end
      end
   end

   task automatic check(input string nm, input int s, input tally_t e);
      tally_t a;
      a = act(s);
      total++;
      if (a !== e || vld_o[s] !== 1'b0) begin
         bad++;
         $display("FAIL %s inst=%0d got=%h vld=%b want=%h vld=0", nm, s, a, vld_o[s], e);
      end
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 10) begin
         @(negedge clk_fpga);
         t++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL ball_valid_timeout pending=%0d got=none want=pulse", exp_q.size());
         exp_q.delete();
         cyc_q.delete();
      end
   endtask

   task automatic press(input logic [3:0] r, input int hold, input bit expect_ball, input tally_t e);
      @(negedge clk_fpga);
      bat_btn = 1'b1;
      rand_in = r;
      if (expect_ball) begin
         exp_q.push_back(e);
         cyc_q.push_back(cyc + 3);
      end
      repeat (hold) @(negedge clk_fpga);
      bat_btn = 1'b0;
      repeat (2) @(negedge clk_fpga);
      drain();
   endtask

   task automatic restart(input string nm);
      @(negedge clk_fpga);
      new_innings = 1'b1;
      @(negedge clk_fpga);
      new_innings = 1'b0;
      check(nm, sel, mk(0, 0, 0, 0, 0, 0, 0));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      bat_btn     = 1'b0;
      new_innings = 1'b0;
      rand_in     = 4'd0;
      #3;
      for (int i = 0; i < 3; i++) check("reset_state", i, mk(0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(negedge clk_fpga);
      reset = 1'b0;

      // First ball: a six, exactly three edges after the press
      sel = 0;
      press(4'd10, 3, 1'b1, mk(6, 0, 1, 0, 6, 0, 0));

      // Six fours complete an over; a long hold counts once
      restart("restart_t2");
      for (int i = 1; i <= 6; i++) press(4'd8, 3, 1'b1, mk(4 * i, 0, i % 6, i / 6, 4, 0, 0));
      press(4'd9, 20, 1'b1, mk(28, 0, 1, 1, 4, 0, 0));

      // Two overs of singles end the innings; later presses are ignored
      restart("restart_t3");
      for (int i = 1; i <= 12; i++)
         press(4'd2, 3, 1'b1, mk(i, 0, i % 6, i / 6, 1, 0, (i == 12) ? 1 : 0));
      press(4'd10, 3, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
      check("frozen_after_done", sel, mk(12, 0, 0, 2, 1, 0, 1));

      // Three wickets end the innings on the instance limited to 3 wickets
      sel = 1;
      restart("restart_t4");
      press(4'd15, 3, 1'b1, mk(0, 1, 1, 0, 0, 1, 0));
      press(4'd14, 3, 1'b1, mk(0, 2, 2, 0, 0, 1, 0));
      press(4'd15, 3, 1'b1, mk(0, 3, 3, 0, 0, 1, 1));

      // Fifty sixes saturate runs at 255
      sel = 2;
      restart("restart_t5");
      for (int i = 1; i <= 50; i++)
         press(4'd10, 3, 1'b1, mk((6 * i > 255) ? 255 : 6 * i, 0, i % 6, i / 6, 6, 0, 0));

      // new_innings coinciding with the press cycle drops the ball
      @(negedge clk_fpga);
      bat_btn = 1'b1;
      rand_in = 4'd10;
      repeat (2) @(negedge clk_fpga);
      new_innings = 1'b1;
      @(negedge clk_fpga);
      new_innings = 1'b0;
      check("new_innings_beats_press", sel, mk(0, 0, 0, 0, 0, 0, 0));
      bat_btn = 1'b0;
      repeat (3) @(negedge clk_fpga);
      press(4'd7, 3, 1'b1, mk(3, 0, 1, 0, 3, 0, 0));

      // Asynchronous reset between clock edges while a press is in flight
      @(negedge clk_fpga);
      bat_btn = 1'b1;
      rand_in = 4'd5;
      @(posedge clk_fpga);
      @(posedge clk_fpga);
      #1;
      reset   = 1'b1;
      bat_btn = 1'b0;
      #1;
      check("async_reset", sel, mk(0, 0, 0, 0, 0, 0, 0));
      #1;
      reset = 1'b0;
      repeat (4) @(negedge clk_fpga);
      check("after_reset_idle", sel, mk(0, 0, 0, 0, 0, 0, 0));
      press(4'd13, 3, 1'b1, mk(1, 0, 1, 0, 1, 0, 0));

      repeat (3) @(negedge clk_fpga);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cricket_ball_scorer.md
Name: cricket_ball_scorer

Overview:
- Consumes the 4-bit pseudo-random value from the game's LFSR stage and turns each bat-button press into one ball outcome: dot, 1, 2, 3, 4, 6 or wicket.
- Keeps the innings tally of runs, wickets, balls-in-over and completed overs, and flags innings end.
- Sits between the LFSR / push-button inputs and the seven-segment/LED display logic.

Parameters:
- MAX_OVERS, 2, number of completed overs that ends the innings (1..15).
- MAX_WICKETS, 10, number of wickets that ends the innings (1..15).

Ports:
- clk_fpga  input  1  system clock; all state is on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- bat_btn  input  1  raw asynchronous bat push-button, active-high.
- new_innings  input  1  synchronous, active-high one-cycle clear of the tally.
- rand_in  input  4  random value from the LFSR stage.
- runs  output  8  total runs; saturates at 255.
- wickets  output  4  wickets fallen.
- balls  output  3  legal balls in the current over, 0..5.
- overs  output  4  completed overs.
- last_runs  output  3  runs credited on the last ball: 0,1,2,3,4,6; 0 on a wicket.
- last_wicket  output  1  1 if the last ball was a wicket.
- ball_valid  output  1  one-cycle pulse when a ball has been scored.
- innings_over  output  1  level; high while in DONE.

Behaviour:
- Reset (async, any time, including mid-update):
  - runs=0, wickets=0, balls=0, overs=0, last_runs=0, last_wicket=0, ball_valid=0, innings_over=0.
  - Synchronizer flops cleared to 0; FSM to PLAY.
- Input conditioning:
  - bat_btn passes through 2 flops (s1, s2), then a history flop s3.
  - press = s2 & ~s3; one press per rising edge of the button; holding the button never repeats.
- Latency: bat_btn high before clock edge k results in updated counters and ball_valid=1 after edge k+2, held for one cycle.
- FSM, two states:
  - PLAY: on press, sample rand_in in that same cycle and score the ball (below). If the post-ball tally hits the end condition, go to DONE in the same update.
  - DONE: innings_over=1; presses are ignored (no ball_valid, counters frozen). new_innings returns to PLAY.
- Outcome map (rand_in -> result):
  - 0,1,12 -> 0 runs
  - 2,3,4,13 -> 1
  - 5,6 -> 2
  - 7 -> 3
  - 8,9 -> 4
  - 10,11 -> 6
  - 14,15 -> wicket
- Ball scoring:
  - runs += credited runs, saturating at 255 (never wraps).
  - A wicket increments wickets.
  - Every ball is legal: if balls==5, then balls<=0 and overs<=overs+1; else balls<=balls+1.
  - last_runs / last_wicket updated and ball_valid pulses.
- End condition after update: wickets==MAX_WICKETS or overs==MAX_OVERS. Both true on the same ball -> single DONE entry, no special case.
- new_innings (any state):
  - Next edge clears runs, wickets, balls, overs, last_runs, last_wicket and innings_over; FSM to PLAY.
  - Synchronizer flops are not cleared.
  - new_innings and press in the same cycle: new_innings wins; the press is dropped, no ball_valid.
- rand_in is only sampled on a press cycle; other values are don't-care.

Test Plan:
1. Reset, then a press with rand_in=10 -> after 3 edges: runs=6, balls=1, last_runs=6, ball_valid high exactly 1 cycle.
2. Six presses with rand_in=8 -> runs=24, balls=0, overs=1. Hold bat_btn high 20 cycles -> only one ball counted.
3. MAX_OVERS=2, twelve presses with rand_in=2 -> runs=12, overs=2, innings_over=1. A 13th press -> no ball_valid, tally unchanged.
4. MAX_WICKETS=3, presses with rand_in=15,14,15 -> wickets=3, runs=0, innings_over=1 after the 3rd ball, last_wicket=1.
5. MAX_OVERS=15, 50 presses with rand_in=10 -> runs saturates at 255, not 44. Then new_innings asserted in the same cycle as a press -> all counters 0, no ball_valid, state PLAY.
6. Assert reset asynchronously mid-cycle right after a press edge -> all outputs 0 immediately without a clock edge. After release, the next press scores normally.
